gpioemu_n: RTL

Parametrised successor to the GPIO emulator peripheral. It sits on the 12-bit emulated bus (`saddress`/`srd`/`swr`) and exposes a bank of `NUM_ARGS` argument registers. Writing the last argument starts a sequential shift-add multiply chain over all arguments. The result, an overflow flag, a completed-operation counter and a latched GPIO input snapshot are all bus-readable, and the low result bits drive `gpio_out`.

---
 rtl/gpioemu_pkg.sv | 33 +++
 rtl/gpioemu_sync_edge.sv | 26 ++
 rtl/gpioemu_n.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/gpioemu_pkg.sv
// Shared types and register-map helpers for the gpioemu_n peripheral.
// Offsets are byte offsets from BASE_ADDR and scale with the argument count.
package gpioemu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_MUL  = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_OVF  = 2;
    localparam int STAT_ERR  = 3;

    function automatic int off_cnt(input int n);
        return 4 * n;
    endfunction

    function automatic int off_status(input int n);
        return 4 * n + 4;
    endfunction

    function automatic int off_result(input int n);
        return 4 * n + 8;
    endfunction

    function automatic int off_gpin(input int n);
        return 4 * n + 12;
    endfunction

endpackage

// File: rtl/gpioemu_sync_edge.sv
// Multi-flop synchroniser followed by a single-cycle rising-edge pulse.
module gpioemu_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_pulse
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_pulse = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/gpioemu_n.sv
// GPIO emulator peripheral: argument bank, sequential shift-add multiply chain,
// status/counter registers and a latched GPIO input snapshot on a 12-bit bus.
module gpioemu_n
    import gpioemu_pkg::*;
#(
    parameter logic [11:0] BASE_ADDR   = 12'h210,
    parameter int          NUM_ARGS    = 2,
    parameter int          GPIO_W      = 8,
    parameter int          SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic [11:0]       saddress,
    input  logic              srd,
    input  logic              swr,
    input  logic [31:0]       sdata_in,
    output logic [31:0]       sdata_out,
    input  logic [GPIO_W-1:0] gpio_in,
    input  logic              gpio_latch,
    output logic [GPIO_W-1:0] gpio_out,
    output logic [31:0]       gpio_in_s_insp
);

    localparam int IDX_W = $clog2(NUM_ARGS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ARGS - 1);

    logic [31:0]       r_args [NUM_ARGS];
    logic [31:0]       r_cnt, r_result, r_acc, r_sdata_out;
    logic [63:0]       r_prod;
    logic [4:0]        r_bit;
    logic [IDX_W-1:0]  r_idx;
    logic              r_done, r_ovf, r_err;
    logic [GPIO_W-1:0] r_gpin, r_gpio_out;
    state_e            r_state;

    logic w_rd_p, w_wr_p, w_latch_p, w_rd, w_wr;
    logic [11:0] w_off;
    logic w_in_win, w_sel_arg, w_sel_cnt, w_sel_stat, w_sel_res, w_sel_gpin;
    logic [IDX_W-1:0] w_arg_idx;
    logic w_busy, w_fin, w_start;
    logic [31:0] w_rdata;
    logic [63:0] w_addend, w_sum;

    gpioemu_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rd (
        .i_clk(clk), .i_rst_n(n_reset), .i_d(srd), .o_pulse(w_rd_p));
    gpioemu_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_wr (
        .i_clk(clk), .i_rst_n(n_reset), .i_d(swr), .o_pulse(w_wr_p));
    gpioemu_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_latch (
        .i_clk(clk), .i_rst_n(n_reset), .i_d(gpio_latch), .o_pulse(w_latch_p));

    // A simultaneous read and write performs only the write.
    assign w_wr = w_wr_p;
    assign w_rd = w_rd_p & ~w_wr_p;

    assign w_off      = saddress - BASE_ADDR;
    assign w_in_win   = (saddress >= BASE_ADDR) && (w_off[1:0] == 2'b00);
    assign w_sel_arg  = w_in_win && (w_off < 12'(off_cnt(NUM_ARGS)));
    assign w_sel_cnt  = w_in_win && (w_off == 12'(off_cnt(NUM_ARGS)));
    assign w_sel_stat = w_in_win && (w_off == 12'(off_status(NUM_ARGS)));
    assign w_sel_res  = w_in_win && (w_off == 12'(off_result(NUM_ARGS)));
    assign w_sel_gpin = w_in_win && (w_off == 12'(off_gpin(NUM_ARGS)));
    assign w_arg_idx  = w_off[IDX_W+1:2];

    assign w_busy  = (r_state != ST_IDLE);
    assign w_fin   = (r_state == ST_FIN);
    assign w_start = w_wr && w_sel_arg && !w_busy && (w_arg_idx == LAST_IDX);

    assign w_addend = r_args[r_idx][r_bit] ? (64'(r_acc) << r_bit) : 64'd0;
    assign w_sum    = r_prod + w_addend;

    // Read mux; done is masked while the FIN update is landing.
    always_comb begin
        w_rdata = 32'd0;
        if (w_sel_arg) begin
            w_rdata = r_args[w_arg_idx];
        end else if (w_sel_cnt) begin
            w_rdata = r_cnt;
        end else if (w_sel_stat) begin
            w_rdata[STAT_BUSY] = w_busy;
            w_rdata[STAT_DONE] = r_done & ~w_fin;
            w_rdata[STAT_OVF]  = r_ovf;
            w_rdata[STAT_ERR]  = r_err;
        end else if (w_sel_res) begin
            w_rdata = r_result;
        end else if (w_sel_gpin) begin
            w_rdata = 32'(r_gpin);
        end else begin
            w_rdata = 32'd0;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < NUM_ARGS; i++) r_args[i] <= 32'd0;
            r_cnt       <= 32'd0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_gpin      <= '0;
            r_sdata_out <= 32'd0;
        end else begin
            if (w_latch_p) r_gpin <= gpio_in;
            if (w_wr && w_sel_arg && !w_busy) r_args[w_arg_idx] <= sdata_in;
            // A bus write to CNT overrides the completion increment.
            if (w_wr && w_sel_cnt) r_cnt <= sdata_in;
            else if (w_fin)        r_cnt <= r_cnt + 32'd1;
            if (w_fin)                    r_done <= 1'b1;
            else if (w_rd && w_sel_stat)  r_done <= 1'b0;
            if (w_wr && w_sel_arg && w_busy) r_err <= 1'b1;
            else if (w_rd && w_sel_stat)     r_err <= 1'b0;
            if (w_rd) r_sdata_out <= w_rdata;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_bit      <= 5'd0;
            r_acc      <= 32'd0;
            r_prod     <= 64'd0;
            r_ovf      <= 1'b0;
            r_result   <= 32'd0;
            r_gpio_out <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_acc   <= r_args[0];
                    r_idx   <= IDX_W'(1);
                    r_bit   <= 5'd0;
                    r_prod  <= 64'd0;
                    r_ovf   <= 1'b0;
                    r_state <= ST_MUL;
                end
                ST_MUL: begin
                    if (r_bit == 5'd31) begin
                        if (w_sum[63:32] != 32'd0) r_ovf <= 1'b1;
                        r_acc  <= w_sum[31:0];
                        r_prod <= 64'd0;
                        r_bit  <= 5'd0;
                        if (r_idx == LAST_IDX) r_state <= ST_FIN;
                        else                   r_idx   <= r_idx + IDX_W'(1);
                    end else begin
                        r_prod <= w_sum;
                        r_bit  <= r_bit + 5'd1;
                    end
                end
                ST_FIN: begin
                    r_result   <= r_acc;
                    r_gpio_out <= r_acc[GPIO_W-1:0];
                    r_state    <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign sdata_out      = r_sdata_out;
    assign gpio_out       = r_gpio_out;
    assign gpio_in_s_insp = 32'(r_gpin);

endmodule
